// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and the
// pointer/count widths derived from it.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port addressed by the FIFO read pointer.
module fifo_mem #(
  parameter int unsigned WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int unsigned DEPTH = fifo_pkg::FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// Synchronous single-clock FIFO: pointers, occupancy count, flags and the
// registered read-data output; storage lives in fifo_mem.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic [WIDTH-1:0]         ip,
  input  logic                     wr,
  input  logic                     rd,
  input  logic                     clk,
  input  logic                     rst,
  output logic [WIDTH-1:0]         op,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] rdata;
  logic             wr_acc;
  logic             rd_acc;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));

  // Written as if-statements so an unknown wr/rd resolves to "not accepted".
  always_comb begin
    wr_acc = 1'b0;
    rd_acc = 1'b0;
    if (wr && !full) begin
      wr_acc = 1'b1;
    end
    if (rd && !empty) begin
      rd_acc = 1'b1;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_W'(1);
      op_d   = rdata;
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && rst),
    .waddr_i (wptr_q),
    .wdata_i (ip),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign op  = op_q;
  assign cnt = cnt_q;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: queue-based reference model compared every cycle, directed
// scenarios with literal expectations, then a randomized soak with resets.
module tb_fifo;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  logic [W-1:0]         ip;
  logic                 wr, rd, clk, rst;
  logic [W-1:0]         op;
  logic                 empty, full;
  logic [$clog2(D):0]   cnt;

  int checks = 0;
  int errors = 0;

  fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .ip(ip), .wr(wr), .rd(rd), .clk(clk), .rst(rst),
    .op(op), .empty(empty), .full(full), .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain queue plus the last value read.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_op = '0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      mq.delete();
      m_op   = '0;
      chk_en = 1'b1;
    end else begin
      bit do_rd, do_wr;
      do_rd = (rd === 1'b1) && (mq.size() != 0);
      do_wr = (wr === 1'b1) && (mq.size() != D);
      if (do_rd) m_op = mq.pop_front();
      if (do_wr) mq.push_back(ip);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_cnt",   32'(cnt),   32'(mq.size()));
      check("model_empty", 32'(empty), 32'(mq.size() == 0));
      check("model_full",  32'(full),  32'(mq.size() == D));
      check("model_op",    32'(op),    32'(m_op));
    end
  end

  task automatic step(input logic w, input logic r, input logic [W-1:0] d, input logic rs = 1'b1);
    wr = w; rd = r; ip = d; rst = rs;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [W-1:0] e_op, input int e_cnt,
                     input logic e_empty, input logic e_full);
    check({name, "_op"},    32'(op),    32'(e_op));
    check({name, "_cnt"},   32'(cnt),   32'(e_cnt));
    check({name, "_empty"}, 32'(empty), 32'(e_empty));
    check({name, "_full"},  32'(full),  32'(e_full));
  endtask

  logic [W-1:0] wdat [4];

  initial begin
    wr = 1'b0; rd = 1'b0; ip = '0; rst = 1'b0;
    wdat[0] = 8'h11; wdat[1] = 8'h06; wdat[2] = 8'h43; wdat[3] = 8'h14;

    // Reset then idle
    step(0, 0, 8'h00, 1'b0);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    lit("idle", 8'h00, 0, 1'b1, 1'b0);

    // Four writes, two reads
    for (int i = 0; i < 4; i++) begin
      step(1, 0, wdat[i]);
      check("wr4_cnt", 32'(cnt), 32'(i + 1));
      check("wr4_empty", 32'(empty), 32'd0);
    end
    step(0, 1, 8'h00);
    lit("rd1", 8'h11, 3, 1'b0, 1'b0);
    step(0, 1, 8'h00);
    lit("rd2", 8'h06, 2, 1'b0, 1'b0);

    // Simultaneous at cnt=2: oldest word (0x43) comes out, cnt holds
    step(1, 1, 8'h77);
    lit("sim2", 8'h43, 2, 1'b0, 1'b0);

    // Read on empty after reset
    step(0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h00);
      lit("rdempty", 8'h00, 0, 1'b1, 1'b0);
    end

    // Fill, overflow attempt, simultaneous at full, drain
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
    lit("fill", 8'h00, 16, 1'b0, 1'b1);
    step(1, 0, 8'hFF);
    lit("ovf", 8'h00, 16, 1'b0, 1'b1);
    step(1, 1, 8'hEE);
    lit("simfull", 8'h00, 15, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 8'h00);
      check("drain_op", 32'(op), 32'(i));
    end
    lit("drained", 8'h0F, 0, 1'b1, 1'b0);

    // Simultaneous at cnt=0: write only, op holds
    step(0, 0, 8'h00, 1'b0);
    step(1, 0, 8'h33);
    step(0, 1, 8'h00);
    lit("pre0", 8'h33, 0, 1'b1, 1'b0);
    step(1, 1, 8'h44);
    lit("sim0", 8'h33, 1, 1'b0, 1'b0);

    // Wrap: 24 writes with a read every other cycle, then trim to cnt=5
    step(0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 24; i++) step(1, (i % 2) == 1, 8'(8'hA0 + i));
    lit("wrap", 8'hAB, 12, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 8'h00);
      check("wrap_op", 32'(op), 32'(8'hAC + i));
    end
    check("wrap_cnt5", 32'(cnt), 32'd5);
    step(1, 1, 8'h99, 1'b0);
    lit("midrst", 8'h00, 0, 1'b1, 1'b0);
    step(1, 0, 8'h5A);
    step(0, 1, 8'h00);
    lit("postrst", 8'h5A, 0, 1'b1, 1'b0);

    // Randomized soak with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic w, r, rs;
      int unsigned mode;
      mode = (i / 500) % 3;
      w  = (mode == 0) ? ($urandom_range(0, 3) != 0) :
           (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      r  = (mode == 0) ? ($urandom_range(0, 3) == 0) :
           (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom);
      rs = ($urandom_range(0, 299) != 0);
      step(w, r, 8'($urandom), rs);
    end

    step(0, 0, 8'h00);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries; power of two.
REQ-003 Port list order SHALL be ip, wr, rd, clk, rst, op, empty, full, cnt, so positional instantiation works.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-006 ip  input  WIDTH  write data, sampled on the rising edge when a write is accepted.
REQ-007 wr  input  1  write request, active-high, level-sampled each cycle.
REQ-008 rd  input  1  read request, active-high, level-sampled each cycle.
REQ-009 op  output  WIDTH  registered read data; holds the last value read.
REQ-010 empty  output  1  high when the occupancy count is 0.
REQ-011 full  output  1  high when the occupancy count equals DEPTH.
REQ-012 cnt  output  $clog2(DEPTH)+1 (5 at default)  current occupancy, 0..DEPTH.

Function
REQ-013 Storage SHALL be first-in first-out: words are read in the order they were written.
REQ-014 A write SHALL be accepted on a rising edge when wr=1 and full=0: ip is stored at the write pointer, and the write pointer increments.
REQ-015 A read SHALL be accepted on a rising edge when rd=1 and empty=0: the word at the read pointer is loaded into op, and the read pointer increments.
REQ-016 Read latency: op SHALL show the read word from the same rising edge that accepts the read, so it is visible in the following cycle.
REQ-017 op SHALL hold its value on cycles with no accepted read, including a rejected read on empty.
REQ-018 A write with full=1 SHALL be ignored: no storage change, no pointer change, no cnt change.
REQ-019 A read with empty=1 SHALL be ignored: op, pointers and cnt are unchanged.
REQ-020 Pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no special handling.
REQ-021 cnt SHALL change as follows:
- increment by 1 on a write-only accept;
- decrement by 1 on a read-only accept;
- unchanged when both or neither are accepted.
REQ-022 Simultaneous wr=1 and rd=1 with 0<cnt<DEPTH SHALL accept both, leaving cnt unchanged.
REQ-023 Simultaneous wr=1 and rd=1 with cnt=0 SHALL accept the write only; op is unchanged and cnt becomes 1.
REQ-024 Simultaneous wr=1 and rd=1 with cnt=DEPTH SHALL accept the read only; cnt becomes DEPTH-1.
REQ-025 empty and full SHALL be decoded combinationally from the registered cnt; they are never both high.
REQ-026 wr and rd SHALL be treated as 0 when X/undriven. A bench SHALL drive them to known values after reset.

Reset
REQ-027 When rst=0 at a rising edge, the following SHALL be set:
- write pointer, read pointer and cnt to 0;
- op to 0;
- empty=1, full=0.
REQ-028 Reset SHALL take priority over any simultaneous wr/rd; requests in a reset cycle are discarded.
REQ-029 Storage array contents need not be cleared by reset; they SHALL never be visible on op before being written.
REQ-030 Reset asserted mid-operation SHALL discard all stored words. After reset the FIFO behaves as freshly empty.

Structure
REQ-031 Shared package fifo_pkg SHALL hold:
- default WIDTH=8 and DEPTH=16 constants;
- derived pointer-width and count-width constants.
REQ-032 One sub-module fifo_mem SHALL contain the DEPTH x WIDTH register array, with one synchronous write port and one read port addressed by the read pointer.
REQ-033 Pointer, count, flag and op logic SHALL reside in fifo itself; no other sub-modules.

Verification
REQ-034 Reset then idle: hold rst=0 for 1 edge, release, wr=rd=0 for 2 cycles -> empty=1, full=0, cnt=0, op=0.
REQ-035 Write 0x11, 0x06, 0x43, 0x14 on four consecutive cycles, then rd=1 for two cycles:
- cnt SHALL step 1,2,3,4 during the writes, with empty=0 after the first write;
- reads SHALL give op=0x11 then op=0x06, with cnt 3 then 2.
REQ-036 Fill: write 16 words 0x00..0x0F -> cnt=16, full=1. A 17th write of 0xFF is ignored. Then 16 reads return 0x00..0x0F in order, ending with empty=1.
REQ-037 Read on empty after reset, rd=1 for 3 cycles -> op stays 0, cnt stays 0, empty stays 1.
REQ-038 Simultaneous wr=rd=1:
- at cnt=2, cnt stays 2 and op gets the oldest word;
- at cnt=0, cnt becomes 1 and op is unchanged;
- at cnt=16, cnt becomes 15.
REQ-039 Wrap and mid-operation reset:
- 24 writes interleaved with reads cross the pointer wrap, with data order preserved;
- then rst=0 for one edge while cnt=5 -> cnt=0, empty=1, op=0, and the next write/read returns the new word.
